// File: rtl/sid_cfg_sequencer.sv
// SCSI-ID config register sequencer: boot-time DIP-chain loader, then host Zorro cycles with wait states.
// Define SID_CFG_SHIFT_EN to build the serial 74HC165 loader; otherwise CFG_DEFAULT is committed after reset.
`timescale 1ns/1ps
module sid_cfg_sequencer #(
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned SCLK_DIV    = 4,
   parameter logic [7:0]  CFG_DEFAULT = 8'hFF
) (
   input  logic       clk,
   input  logic       IORST_n,
   input  logic       sid_cycle,
   input  logic       DOE,
   input  logic       DS0_n,
   input  logic       READ,
   input  logic [7:0] DIN,
   input  logic       cfg_sdo,
   output logic       cfg_sclk,
   output logic       cfg_pl_n,
   output logic       reg_we,
   output logic [7:0] reg_wdata,
   output logic       reg_rd,
   output logic       dtack,
   output logic       busy
);

   typedef enum logic [2:0] {ST_PL, ST_SHIFT, ST_COMMIT, ST_IDLE, ST_WAIT, ST_ACK, ST_HOLD} state_t;

   localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

   state_t     state_q;
   logic [3:0] wait_q;
   logic [7:0] din_q;
   logic       read_q;
   logic       we_q;
   logic [7:0] wdata_q;
   logic       rd_q;
   logic       dtack_q;
   logic       busy_q;
   logic       strobe_d;
   logic       start_d;

   assign strobe_d = sid_cycle & ~DS0_n;
   assign start_d  = strobe_d & DOE;

`ifdef SID_CFG_SHIFT_EN
   localparam int DIV_W = $clog2(SCLK_DIV + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(SCLK_DIV);
   localparam state_t RST_STATE = ST_PL;

   logic [DIV_W-1:0] div_q;
   logic [2:0]       bit_q;
   logic [7:0]       shift_q;
   logic [7:0]       shift_d;
   logic             sclk_q;
   logic             pl_n_q;
   logic             cfg_unused;

   assign shift_d    = {shift_q[6:0], cfg_sdo};
   assign cfg_sclk   = sclk_q;
   assign cfg_pl_n   = pl_n_q;
   assign cfg_unused = ^CFG_DEFAULT;
`else
   localparam state_t RST_STATE = ST_COMMIT;

   logic sdo_unused;

   assign cfg_sclk   = 1'b0;
   assign cfg_pl_n   = 1'b1;
   assign sdo_unused = cfg_sdo ^ (SCLK_DIV == 0);
`endif

   always_ff @(posedge clk) begin
      if (!IORST_n) begin
         state_q <= RST_STATE;
         wait_q  <= 4'd0;
         we_q    <= 1'b0;
         wdata_q <= 8'h00;
         rd_q    <= 1'b0;
         dtack_q <= 1'b0;
         busy_q  <= 1'b1;
`ifdef SID_CFG_SHIFT_EN
         div_q   <= '0;
         bit_q   <= 3'd0;
         sclk_q  <= 1'b0;
         pl_n_q  <= 1'b1;
`endif
      end else begin
         we_q <= 1'b0;
         rd_q <= 1'b0;
         case (state_q)
`ifdef SID_CFG_SHIFT_EN
            ST_PL: begin
               if (div_q == DIV_MAX) begin
                  pl_n_q  <= 1'b1;
                  div_q   <= '0;
                  bit_q   <= 3'd7;
                  state_q <= ST_SHIFT;
               end else begin
                  pl_n_q <= 1'b0;
                  div_q  <= div_q + 1'b1;
               end
            end
            // QH is sampled at the end of the low half, just before the chain shifts on the rising edge
            ST_SHIFT: begin
               if (div_q == DIV_LAST) begin
                  div_q <= '0;
                  if (!sclk_q) begin
                     shift_q <= shift_d;
                     sclk_q  <= 1'b1;
                  end else begin
                     sclk_q <= 1'b0;
                     if (bit_q == 3'd0) state_q <= ST_COMMIT;
                     else               bit_q   <= bit_q - 1'b1;
                  end
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            ST_COMMIT: begin
               we_q    <= 1'b1;
               wdata_q <= shift_q;
               state_q <= ST_IDLE;
            end
`else
            ST_COMMIT: begin
               we_q    <= 1'b1;
               wdata_q <= CFG_DEFAULT;
               state_q <= ST_IDLE;
            end
`endif
            ST_IDLE: begin
               busy_q  <= 1'b0;
               dtack_q <= 1'b0;
               if (start_d) begin
                  din_q   <= DIN;
                  read_q  <= READ;
                  wait_q  <= 4'd0;
                  state_q <= (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!strobe_d)               state_q <= ST_IDLE;
               else if (wait_q == WAIT_LAST) state_q <= ST_ACK;
               else                          wait_q  <= wait_q + 1'b1;
            end
            ST_ACK: begin
               if (read_q) begin
                  rd_q <= 1'b1;
               end else begin
                  we_q    <= 1'b1;
                  wdata_q <= din_q;
               end
               dtack_q <= 1'b1;
               state_q <= ST_HOLD;
            end
            // Wait for strobe release so a held strobe cannot start a second access
            ST_HOLD: begin
               if (!strobe_d) begin
                  dtack_q <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign reg_we    = we_q;
   assign reg_wdata = wdata_q;
   assign reg_rd    = rd_q;
   assign dtack     = dtack_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_sid_cfg_sequencer.sv
// Directed bench for sid_cfg_sequencer: three instances (WAIT_STATES 1/0/3) share stimulus and a 74HC165 model.
// Expected values follow the SID_CFG_SHIFT_EN build setting.
`timescale 1ns/1ps
module tb_sid_cfg_sequencer;
   localparam logic [7:0] CFG_DEF = 8'h5A;

   logic       clk = 1'b0;
   logic       IORST_n, sid_cycle, DOE, DS0_n, READ;
   logic [7:0] DIN;
   logic       cfg_sdo;
   logic       sclk1, pln1, we1, rd1, dt1, bz1;
   logic       sclk0, pln0, we0, rd0, dt0, bz0;
   logic       sclk3, pln3, we3, rd3, dt3, bz3;
   logic [7:0] wd1, wd0, wd3;
   logic [7:0] dip;
   logic [7:0] chain = 8'h00;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   sid_cfg_sequencer #(.WAIT_STATES(1), .SCLK_DIV(2), .CFG_DEFAULT(CFG_DEF)) u_ws1 (
      .clk(clk), .IORST_n(IORST_n), .sid_cycle(sid_cycle), .DOE(DOE), .DS0_n(DS0_n), .READ(READ),
      .DIN(DIN), .cfg_sdo(cfg_sdo), .cfg_sclk(sclk1), .cfg_pl_n(pln1), .reg_we(we1), .reg_wdata(wd1),
      .reg_rd(rd1), .dtack(dt1), .busy(bz1));
   sid_cfg_sequencer #(.WAIT_STATES(0), .SCLK_DIV(2), .CFG_DEFAULT(CFG_DEF)) u_ws0 (
      .clk(clk), .IORST_n(IORST_n), .sid_cycle(sid_cycle), .DOE(DOE), .DS0_n(DS0_n), .READ(READ),
      .DIN(DIN), .cfg_sdo(cfg_sdo), .cfg_sclk(sclk0), .cfg_pl_n(pln0), .reg_we(we0), .reg_wdata(wd0),
      .reg_rd(rd0), .dtack(dt0), .busy(bz0));
   sid_cfg_sequencer #(.WAIT_STATES(3), .SCLK_DIV(2), .CFG_DEFAULT(CFG_DEF)) u_ws3 (
      .clk(clk), .IORST_n(IORST_n), .sid_cycle(sid_cycle), .DOE(DOE), .DS0_n(DS0_n), .READ(READ),
      .DIN(DIN), .cfg_sdo(cfg_sdo), .cfg_sclk(sclk3), .cfg_pl_n(pln3), .reg_we(we3), .reg_wdata(wd3),
      .reg_rd(rd3), .dtack(dt3), .busy(bz3));

   // 74HC165: parallel load while PL is low, shift toward QH on each SCLK rise
   always @(negedge pln1 or posedge sclk1) begin
      if (!pln1) chain <= dip;
      else       chain <= {chain[6:0], 1'b0};
   end
   assign cfg_sdo = chain[7];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host(input logic s, input logic doe, input logic ds_n, input logic rd, input logic [7:0] d);
      sid_cycle = s; DOE = doe; DS0_n = ds_n; READ = rd; DIN = d;
   endtask

   task automatic run_load(input int max_e, input int host_e,
                           output int pl_low, output int sclk_rise, output int we_cnt,
                           output int we1_e, output logic [7:0] we1_d,
                           output int we2_e, output logic [7:0] we2_d,
                           output int busy_fall, output int dtack_e);
      logic prev_sclk;
      prev_sclk = 1'b0;
      pl_low = 0; sclk_rise = 0; we_cnt = 0; we1_e = 0; we2_e = 0;
      busy_fall = 0; dtack_e = 0; we1_d = 8'h00; we2_d = 8'h00;
      for (int e = 1; e <= max_e; e++) begin
         tick();
         if (!pln1) pl_low++;
         if (sclk1 && !prev_sclk) sclk_rise++;
         prev_sclk = sclk1;
         if (we1) begin
            we_cnt++;
            if (we_cnt == 1) begin we1_e = e; we1_d = wd1; end
            else if (we_cnt == 2) begin we2_e = e; we2_d = wd1; end
         end
         if (!bz1 && busy_fall == 0) busy_fall = e;
         if (dt1 && dtack_e == 0) dtack_e = e;
         if (e == host_e) host(1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
      end
   endtask

   initial begin
      int pl_low, sclk_rise, we_cnt, we1_e, we2_e, busy_fall, dtack_e;
      logic [7:0] we1_d, we2_d, seen_d;
      int cnt, first, rdc;

      IORST_n = 1'b0;
      host(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      dip = 8'hA5;
      tick(); tick();
      check_eq("rst_ctl_ws1", 32'({sclk1, pln1, we1, rd1, dt1, bz1}), 32'b010001);
      check_eq("rst_ctl_ws0", 32'({sclk0, pln0, we0, rd0, dt0, bz0}), 32'b010001);
      check_eq("rst_ctl_ws3", 32'({sclk3, pln3, we3, rd3, dt3, bz3}), 32'b010001);
      check_eq("rst_wdata", 32'({wd1, wd0, wd3}), 32'h0);

      // T1: boot load
      IORST_n = 1'b1;
`ifdef SID_CFG_SHIFT_EN
      run_load(45, -1, pl_low, sclk_rise, we_cnt, we1_e, we1_d, we2_e, we2_d, busy_fall, dtack_e);
      check_eq("t1_pl_low", pl_low, 2);
      check_eq("t1_sclk_pulses", sclk_rise, 8);
      check_eq("t1_we_edge", we1_e, 36);
      check_eq("t1_wdata", 32'(we1_d), 32'hA5);
      check_eq("t1_busy_fall", busy_fall, 37);
`else
      run_load(12, -1, pl_low, sclk_rise, we_cnt, we1_e, we1_d, we2_e, we2_d, busy_fall, dtack_e);
      check_eq("t1_pl_low", pl_low, 0);
      check_eq("t1_sclk_pulses", sclk_rise, 0);
      check_eq("t1_we_edge", we1_e, 1);
      check_eq("t1_wdata", 32'(we1_d), 32'(CFG_DEF));
      check_eq("t1_busy_fall", busy_fall, 2);
`endif
      check_eq("t1_we_count", we_cnt, 1);
      check_eq("t1_no_dtack", dtack_e, 0);
      check_eq("t1_ws3_wdata", 32'(wd3), 32'(we1_d));

      // T2: host write, WAIT_STATES=1, strobe held 6 edges
      host(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
      cnt = 0; first = 0; rdc = 0; seen_d = 8'h00;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (we1) begin cnt++; if (first == 0) begin first = i; seen_d = wd1; end end
         if (rd1) rdc++;
         if (i == 3) check_eq("t2_dtack_with_we", 32'(dt1), 32'd1);
         if (i == 6) check_eq("t2_dtack_held", 32'(dt1), 32'd1);
      end
      check_eq("t2_we_latency", first, 3);
      check_eq("t2_wdata", 32'(seen_d), 32'h3C);
      check_eq("t2_no_rd", rdc, 0);
      host(1'b1, 1'b1, 1'b1, 1'b0, 8'h3C);
      tick();
      check_eq("t2_dtack_release", 32'(dt1), 32'd0);
      if (we1) cnt++;
      host(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) begin tick(); if (we1) cnt++; end
      check_eq("t2_single_we", cnt, 1);

      // T3: host read, WAIT_STATES=0
      host(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
      cnt = 0;
      tick();
      check_eq("t3_rd_early", 32'(rd0), 32'd0);
      if (we0) cnt++;
      tick();
      check_eq("t3_rd", 32'(rd0), 32'd1);
      check_eq("t3_dtack", 32'(dt0), 32'd1);
      if (we0) cnt++;
      tick();
      check_eq("t3_rd_pulse", 32'(rd0), 32'd0);
      check_eq("t3_ws1_rd", 32'(rd1), 32'd1);
      if (we0) cnt++;
      host(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
      tick();
      check_eq("t3_dtack_release", 32'(dt0), 32'd0);
      if (we0) cnt++;
      host(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) begin tick(); if (we0) cnt++; end
      check_eq("t3_no_we", cnt, 0);

      // T5: strobe lost during WAIT (WAIT_STATES=3), then a full write proves IDLE
      host(1'b1, 1'b1, 1'b0, 1'b0, 8'h44);
      cnt = 0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 2) host(1'b1, 1'b1, 1'b1, 1'b0, 8'h44);
         if (we3 || rd3 || dt3) cnt++;
      end
      check_eq("t5_abort_quiet", cnt, 0);
      host(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
      cnt = 0; first = 0; seen_d = 8'h00;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (we3) begin cnt++; if (first == 0) begin first = i; seen_d = wd3; end end
      end
      check_eq("t5_retry_latency", first, 5);
      check_eq("t5_retry_wdata", 32'(seen_d), 32'h77);
      check_eq("t5_retry_count", cnt, 1);
      host(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      tick(); tick();

      // T6 + T4: reset mid-load, full reload, host write queued behind the loader
      IORST_n = 1'b0;
      tick();
      IORST_n = 1'b1;
`ifdef SID_CFG_SHIFT_EN
      for (int i = 0; i < 12; i++) tick();
`else
      tick();
`endif
      IORST_n = 1'b0;
      tick();
      check_eq("t6_rst_ctl", 32'({sclk1, pln1, we1, rd1, dt1, bz1}), 32'b010001);
      check_eq("t6_rst_wdata", 32'(wd1), 32'h0);
      dip = 8'hC3;
      IORST_n = 1'b1;
`ifdef SID_CFG_SHIFT_EN
      run_load(50, 20, pl_low, sclk_rise, we_cnt, we1_e, we1_d, we2_e, we2_d, busy_fall, dtack_e);
      check_eq("t6_pl_low", pl_low, 2);
      check_eq("t6_sclk_pulses", sclk_rise, 8);
      check_eq("t6_we_edge", we1_e, 36);
      check_eq("t6_wdata", 32'(we1_d), 32'hC3);
      check_eq("t4_host_we_edge", we2_e, 39);
      check_eq("t4_dtack_edge", dtack_e, 39);
      check_eq("t6_busy_fall", busy_fall, 37);
`else
      run_load(12, 1, pl_low, sclk_rise, we_cnt, we1_e, we1_d, we2_e, we2_d, busy_fall, dtack_e);
      check_eq("t6_pl_low", pl_low, 0);
      check_eq("t6_sclk_pulses", sclk_rise, 0);
      check_eq("t6_we_edge", we1_e, 1);
      check_eq("t6_wdata", 32'(we1_d), 32'(CFG_DEF));
      check_eq("t4_host_we_edge", we2_e, 4);
      check_eq("t4_dtack_edge", dtack_e, 4);
      check_eq("t6_busy_fall", busy_fall, 2);
`endif
      check_eq("t4_we_count", we_cnt, 2);
      check_eq("t4_host_wdata", 32'(we2_d), 32'h11);
      host(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      tick();
      check_eq("t4_dtack_release", 32'(dt1), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
